// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port DRAM arbiter and access sequencer (DRAM_ARB_RR_EN selects round-robin arbitration)
module dram_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          We0,
  input  logic          We1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData0,
  input  logic [DW-1:0] WData1,
  output logic          Ack0,
  output logic          Ack1,
  output logic [DW-1:0] RData,
  output logic          Busy,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemDataOut,
  output logic          MemRD,
  output logic          MemWR,
  input  logic [DW-1:0] MemDataIn
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Wait-counter reload: WAIT lasts RD_LAT cycles, capture happens when it reaches zero.
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;

  logic            grant_sel;
  logic            sel_we;

  // Port chosen if arbitration happens this cycle (only consumed in IDLE).
  always_comb begin
    grant_sel = 1'b0;
`ifdef DRAM_ARB_RR_EN
    if (Req0 && Req1) begin
      grant_sel = ~last_q;
    end else begin
      grant_sel = Req1;
    end
`else
    grant_sel = ~Req0;
`endif
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    rdata_d     = rdata_q;
    sel_we      = grant_sel ? We1 : We0;

    case (state_q)
      S_IDLE: begin
        if (Req0 || Req1) begin
          grant_d     = grant_sel;
          last_d      = grant_sel;
          we_d        = sel_we;
          mem_addr_d  = grant_sel ? Addr1 : Addr0;
          mem_wdata_d = grant_sel ? WData1 : WData0;
          mem_rd_d    = ~sel_we;
          mem_wr_d    = sel_we;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = MemDataIn;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack0_d = (state_d == S_DONE) && !grant_d;
    ack1_d = (state_d == S_DONE) &&  grant_d;
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign Ack0       = ack0_q;
  assign Ack1       = ack1_q;
  assign RData      = rdata_q;
  assign Busy       = busy_q;
  assign MemAddr    = mem_addr_q;
  assign MemDataOut = mem_wdata_q;
  assign MemRD      = mem_rd_q;
  assign MemWR      = mem_wr_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter against a transaction-level reference model
module tb_dram_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 3;

  logic          Clk1 = 1'b0;
  logic          Reset;
  logic          Req0, Req1, We0, We1;
  logic [AW-1:0] Addr0, Addr1;
  logic [DW-1:0] WData0, WData1;
  logic          Ack0, Ack1, Busy, MemRD, MemWR;
  logic [DW-1:0] RData, MemDataOut, MemDataIn;
  logic [AW-1:0] MemAddr;

  dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .Clk1(Clk1), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Busy(Busy),
    .MemAddr(MemAddr), .MemDataOut(MemDataOut),
    .MemRD(MemRD), .MemWR(MemWR), .MemDataIn(MemDataIn)
  );

  always #5 Clk1 = ~Clk1;

  // DRAM behaviour: data for a read becomes valid RD_LAT-1 edges after RD is seen, garbage before.
  logic [DW-1:0] dram_mem [0:65535];
  int            dcnt = 0;
  logic [AW-1:0] daddr;
  always @(posedge Clk1) begin
    if (MemWR) dram_mem[MemAddr] <= MemDataOut;
    if (MemRD) begin
      daddr     <= MemAddr;
      dcnt      <= RD_LAT - 1;
      MemDataIn <= (RD_LAT == 1) ? dram_mem[MemAddr] : DW'($urandom);
    end else if (dcnt > 0) begin
      dcnt      <= dcnt - 1;
      MemDataIn <= (dcnt == 1) ? dram_mem[daddr] : DW'($urandom);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] ref_mem [0:65535];
  bit            pend [2];
  bit            pwe [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];
  int            last_m;
  logic [DW-1:0] rdata_m;

  function automatic int pick();
`ifdef DRAM_ARB_RR_EN
    if (pend[0] && pend[1]) return (last_m == 0) ? 1 : 0;
`endif
    return pend[0] ? 0 : 1;
  endfunction

  task automatic drive_pins();
    Req0 = pend[0]; We0 = pwe[0]; Addr0 = paddr[0]; WData0 = pdata[0];
    Req1 = pend[1]; We1 = pwe[1]; Addr1 = paddr[1]; WData1 = pdata[1];
  endtask

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pwe[p] = we; paddr[p] = a; pdata[p] = d;
  endtask

  task automatic new_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(p, we, a, d);
    pend[p] = 1'b1;
  endtask

  task automatic rnd_set(input int p);
    set_req(p, bit'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom));
  endtask

  // One transaction, starting 1 time unit after an edge with the DUT in IDLE.
  task automatic do_txn(input string tag, input bit regrant, input int late_port, input bit early_drop);
    int            exp_p, cyc, nrd, nwr, obs_p, exp_lat;
    bit            got, ewe;
    logic [AW-1:0] ea, acc_addr;
    logic [DW-1:0] ed, acc_data;
    drive_pins();
    exp_p = pick();
    ewe = pwe[exp_p]; ea = paddr[exp_p]; ed = pdata[exp_p];
    exp_lat = ewe ? 2 : 2 + RD_LAT;
    got = 1'b0; nrd = 0; nwr = 0; acc_addr = '0; acc_data = '0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(posedge Clk1); #1;
      if (MemRD) nrd++;
      if (MemWR) nwr++;
      if (cyc == 1) begin
        chk({tag, "/busy_rise"}, 32'(Busy), 32'd1);
        acc_addr = MemAddr;
        acc_data = MemDataOut;
        if (late_port >= 0) begin
          pend[late_port] = 1'b1;
          drive_pins();
        end
        if (early_drop) begin
          if (exp_p == 0) Req0 = 1'b0; else Req1 = 1'b0;
        end
      end
      if (Ack0 || Ack1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "/ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      obs_p = Ack1 ? 1 : 0;
      chk({tag, "/port"}, 32'(obs_p), 32'(exp_p));
      chk({tag, "/two_acks"}, 32'(Ack0 & Ack1), 32'd0);
      chk({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "/rd_pulses"}, 32'(nrd), ewe ? 32'd0 : 32'd1);
      chk({tag, "/wr_pulses"}, 32'(nwr), ewe ? 32'd1 : 32'd0);
      chk({tag, "/acc_addr"}, 32'(acc_addr), 32'(ea));
      if (ewe) chk({tag, "/acc_wdata"}, 32'(acc_data), 32'(ed));
      chk({tag, "/addr_hold"}, 32'(MemAddr), 32'(ea));
      if (ewe) ref_mem[ea] = ed;
      else rdata_m = ref_mem[ea];
      chk({tag, "/rdata"}, 32'(RData), 32'(rdata_m));
    end
    last_m = exp_p;
    if (!regrant) pend[exp_p] = 1'b0;
    drive_pins();
    @(posedge Clk1); #1;
    chk({tag, "/idle_busy"}, 32'(Busy), 32'd0);
    chk({tag, "/idle_ack"}, 32'({Ack0, Ack1}), 32'd0);
  endtask

  task automatic reset_dut();
    Reset = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_pins();
    @(posedge Clk1); #1;
    Reset = 1'b1;
    last_m = 1; rdata_m = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int late;
    bit edrop;
    int noack;
    Reset = 1'b0;
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, '0, '0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_pins();
    last_m = 1; rdata_m = '0;

    // Reset state.
    repeat (2) @(posedge Clk1);
    #1;
    chk("rst/busy", 32'(Busy), 32'd0);
    chk("rst/acks", 32'({Ack0, Ack1}), 32'd0);
    chk("rst/rdata", 32'(RData), 32'd0);
    chk("rst/memrdwr", 32'({MemRD, MemWR}), 32'd0);
    chk("rst/memaddr", 32'(MemAddr), 32'd0);
    chk("rst/memdout", 32'(MemDataOut), 32'd0);
    Reset = 1'b1;

    // Single write then read of the same location.
    new_req(0, 1'b1, 16'h0040, 16'hBEEF);
    do_txn("wr40", 1'b0, -1, 1'b0);
    new_req(0, 1'b0, 16'h0040, 16'h0000);
    do_txn("rd40", 1'b0, -1, 1'b0);

    // Port 1 raises its request while port 0's write is in ACCESS.
    new_req(0, 1'b1, 16'h0044, 16'h1234);
    set_req(1, 1'b1, 16'h0123, 16'h5A5A);
    do_txn("busy_p0", 1'b0, 1, 1'b0);
    do_txn("busy_p1", 1'b0, -1, 1'b0);

    // Continuous contention from a fresh reset, then the winner drops out.
    reset_dut();
    new_req(0, 1'b1, 16'h0050, 16'h0A0A);
    new_req(1, 1'b1, 16'h0051, 16'h0B0B);
    for (int k = 0; k < 3; k++) do_txn("cont", 1'b1, -1, 1'b0);
    do_txn("cont_last", 1'b0, -1, 1'b0);
    do_txn("cont_other", 1'b0, -1, 1'b0);

    // Request dropped right after grant still completes.
    new_req(1, 1'b0, 16'h0040, 16'h0000);
    do_txn("early_drop", 1'b0, -1, 1'b1);

    // Fill the random address pool.
    for (int i = 0; i < 16; i++) begin
      new_req(i % 2, 1'b1, 16'h0100 + 16'(i), 16'($urandom));
      do_txn("fill", 1'b0, -1, 1'b0);
    end

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      late = -1;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          rnd_set(p);
          pend[p] = 1'b1;
        end
      end
      if (!pend[0] && !pend[1]) begin
        late = int'($urandom_range(0, 1));
        rnd_set(late);
        pend[late] = 1'b1;
        late = -1;
      end
      if (!(pend[0] && pend[1]) && $urandom_range(0, 3) == 0) begin
        late = pend[0] ? 1 : 0;
        rnd_set(late);
      end
      edrop = ($urandom_range(0, 3) == 0);
      do_txn("rnd", 1'b0, late, edrop);
    end
    // Drain whatever is still pending.
    for (int k = 0; k < 2; k++) begin
      if (pend[0] || pend[1]) do_txn("drain", 1'b0, -1, 1'b0);
    end

    // Reset asserted while a read is waiting on the DRAM.
    new_req(0, 1'b0, 16'h0040, 16'h0000);
    drive_pins();
    repeat (2) begin
      @(posedge Clk1); #1;
    end
    Reset = 1'b0;
    #1;
    chk("midrst/memrd", 32'(MemRD), 32'd0);
    chk("midrst/acks", 32'({Ack0, Ack1}), 32'd0);
    chk("midrst/rdata", 32'(RData), 32'd0);
    chk("midrst/busy", 32'(Busy), 32'd0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_pins();
    @(posedge Clk1); #1;
    Reset = 1'b1;
    last_m = 1; rdata_m = '0;
    noack = 0;
    repeat (6) begin
      @(posedge Clk1); #1;
      if (Ack0 || Ack1 || Busy || MemRD || MemWR) noack++;
    end
    chk("midrst/quiet", 32'(noack), 32'd0);
    new_req(0, 1'b0, 16'h0040, 16'h0000);
    do_txn("after_rst", 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter and sequencer sharing the single DRAM between the CVP14 core (port 0) and a second master such as a DMA or test loader (port 1). Accepts one request at a time, drives the DRAM `RD`/`WR`/`Addr`/`DataIn` pins for exactly one access, waits out the read latency, and returns read data with a one-cycle acknowledge. Sits between the masters and the `DRAM` instance at top level.

## Interface
- `AW`, 16, address width.
- `DW`, 16, data width.
- `RD_LAT`, 1, DRAM read latency in cycles, legal range 1..7.
- `Clk1`  in  1  single clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Req0` / `Req1`  in  1  per-port request; held high until the matching `Ack`.
- `We0` / `We1`  in  1  per-port 1 = write, 0 = read; valid while `Req` is high.
- `Addr0` / `Addr1`  in  AW  per-port address.
- `WData0` / `WData1`  in  DW  per-port write data.
- `Ack0` / `Ack1`  out  1  one-cycle completion pulse.
- `RData`  out  DW  read data for the port being acknowledged; shared by both ports.
- `Busy`  out  1  high in any state other than IDLE.
- `MemAddr`  out  AW  to DRAM `Addr`.
- `MemDataOut`  out  DW  to DRAM `DataIn`.
- `MemRD` / `MemWR`  out  1  to DRAM `RD` / `WR`.
- `MemDataIn`  in  DW  from DRAM `DataOut`.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE
  - If no `Req` is high, stay in IDLE.
  - Otherwise pick the grantee, latch its `We`, `Addr` and `WData` into `MemAddr` and `MemDataOut`, then go to ACCESS.
- ACCESS
  - `MemRD` = !we and `MemWR` = we, asserted for exactly one cycle.
  - Write: go to DONE.
  - Read: load the wait counter with `RD_LAT - 1` and go to WAIT.
- WAIT
  - Counter decrements each cycle.
  - At counter = 0, capture `MemDataIn` into `RData` and go to DONE.
- DONE: `Ack` of the grantee is high for one cycle, then return to IDLE.
- `MemAddr` and `MemDataOut` hold their value from ACCESS through DONE. `MemRD` and `MemWR` are 0 outside ACCESS.
- `RData` holds its value until the next read capture. Writes do not change it.
- Arbitration is decided only in IDLE. A `Req` raised during a transaction waits in IDLE and is not lost.
- A `Req` dropped early does not abort the transaction; the `Ack` still pulses.
- A requester that keeps `Req` high in the cycle after `Ack` is granted a new transaction.
- `Ack0` and `Ack1` are never high in the same cycle.
- Grant pointer `last`: updated to the grantee in IDLE; reset value 1.

## Timing
- Reset (asynchronous, `Reset` = 0): state IDLE; all outputs 0, including `RData` and `Busy`; `last` = 1. An in-flight transaction is abandoned with no `Ack` and no further `MemRD`/`MemWR`.
- `Req` is sampled at edge 0 while in IDLE.
  - Write: `MemWR` is high between edge 0 and edge 1; `Ack` is high between edge 1 and edge 2.
  - Read: `MemRD` is high between edge 0 and edge 1; `RData` captured at edge `1 + RD_LAT`; `Ack` is high for the cycle that follows.
- Throughput: back-to-back writes complete one every 3 cycles. Back-to-back reads complete one every `RD_LAT + 3` cycles.
- `Busy` rises at edge 0 and falls at the edge that ends DONE.

## Configuration
- `DRAM_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests, the port ≠ `last` wins.
  - A lone request always wins.
- `DRAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. `last` is still tracked but ignored.

## Test plan
- Reset mid-read: assert `Reset` low during WAIT -> next cycle `MemRD`, `Ack0`, `Ack1`, `RData` and `Busy` are 0. After release, a new `Req0` completes normally.
- Single write then read, `RD_LAT` = 1:
  - `Req0` write `Addr0` = 16'h0040, `WData0` = 16'hBEEF -> `MemWR` high 1 cycle with `MemAddr` = 16'h0040, `Ack0` 2 cycles after the sample.
  - Then read 16'h0040 -> `RData` = 16'hBEEF with `Ack0` 3 cycles after the sample.
- Read latency sweep, `RD_LAT` = 3: read -> `Ack` 5 cycles after the sample. `MemRD` is a single-cycle pulse.
- Contention with `DRAM_ARB_RR_EN`: `Req0` and `Req1` held high continuously for 4 transactions -> grant order 0, 1, 0, 1.
- Contention without `DRAM_ARB_RR_EN`: the same stimulus -> grant order 0, 0, 0, 0 while `Req0` stays high. After `Req0` drops, port 1 is granted.
- Request during busy: `Req1` raised in ACCESS of a port-0 write -> `Ack0` first. Port 1 is granted in the IDLE cycle that follows, with `MemAddr` = `Addr1`.
